lcd_host: RTL and testbench

LCD_HOST -- requirements
Module: lcd_host

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_host_if.sv | 29 ++
 rtl/lcd_win_buf.sv | 25 ++
 rtl/lcd_host.sv | 123 ++++++++++++
 tb/tb_lcd_host.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Command codes, FSM state encoding and default sizing shared by the LCD host blocks.
package lcd_pkg;

   typedef enum logic [2:0] {
      CMD_REFRESH  = 3'd0,
      CMD_LOAD     = 3'd1,
      CMD_ZOOM_IN  = 3'd2,
      CMD_ZOOM_OUT = 3'd3,
      CMD_SHIFT_R  = 3'd4,
      CMD_SHIFT_L  = 3'd5,
      CMD_SHIFT_U  = 3'd6,
      CMD_SHIFT_D  = 3'd7
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LOAD,
      S_WAIT,
      S_DONE
   } state_e;

   localparam int DEF_IMG_PIXELS = 64;
   localparam int DEF_WIN_PIXELS = 16;
   localparam int DEF_TIMEOUT    = 200;

endpackage

// File: rtl/lcd_host_if.sv
// Bundle of upstream request, image ROM, LCD controller and window-read signals around lcd_host.
// master = the host itself; slave = the surrounding requester, ROM and LCD controller.
interface lcd_host_if;
   logic       req_valid;
   logic [2:0] req_cmd;
   logic       req_ready;
   logic [5:0] img_addr;
   logic [7:0] img_data;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic [7:0] datain;
   logic       busy;
   logic [7:0] dataout;
   logic       output_valid;
   logic [3:0] win_addr;
   logic [7:0] win_data;
   logic       done;
   logic       err;

   modport master (
      input  req_valid, req_cmd, img_data, busy, dataout, output_valid, win_addr,
      output req_ready, img_addr, cmd, cmd_valid, datain, win_data, done, err
   );

   modport slave (
      output req_valid, req_cmd, img_data, busy, dataout, output_valid, win_addr,
      input  req_ready, img_addr, cmd, cmd_valid, datain, win_data, done, err
   );
endinterface

// File: rtl/lcd_win_buf.sv
// Window capture buffer: one synchronous write port, one combinational read port.
// Contents are don't-care after reset, so the array carries no reset.
module lcd_win_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_host.sv
// LCD host: accepts one command, strobes it to the controller, streams the image on LOAD and captures the window.
// Strobe waits on busy; datain trails img_addr by one cycle; requests are taken only when idle.
module lcd_host
   import lcd_pkg::*;
#(
   parameter int IMG_PIXELS = DEF_IMG_PIXELS,
   parameter int WIN_PIXELS = DEF_WIN_PIXELS,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   lcd_host_if.master bus
);
   localparam int             WCW       = $clog2(TIMEOUT + 1);
   localparam logic [5:0]     PIX_LAST  = 6'(IMG_PIXELS - 1);
   localparam logic [4:0]     WIN_FULL  = 5'(WIN_PIXELS);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   state_e         state_q, state_d;
   cmd_e           cmd_q, cmd_d;
   logic [5:0]     pix_q, pix_d;
   logic [4:0]     beat_q, beat_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic           err_q, err_d;

   logic accept, strobe, beat_vld, beat_wr, wait_rel, wait_tmo, wait_exit;

   assign accept    = (state_q == S_IDLE) && bus.req_valid;
   assign strobe    = (state_q == S_ISSUE) && !bus.busy;
   assign beat_vld  = (state_q != S_IDLE) && bus.output_valid;
   assign beat_wr   = beat_vld && (beat_q < WIN_FULL);
   // Non-LOAD commands reach WAIT one cycle after the strobe; give the controller a cycle to raise busy.
   assign wait_rel  = !bus.busy && ((wait_q != '0) || (cmd_q == CMD_LOAD));
   assign wait_tmo  = (wait_q == WAIT_LAST);
   assign wait_exit = (state_q == S_WAIT) && (wait_rel || wait_tmo);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cmd_q   <= CMD_REFRESH;
         pix_q   <= '0;
         beat_q  <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         pix_q   <= pix_d;
         beat_q  <= beat_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_ISSUE;
         S_ISSUE: if (strobe) state_d = (cmd_q == CMD_LOAD) ? S_LOAD : S_WAIT;
         S_LOAD:  if (pix_q == PIX_LAST) state_d = S_WAIT;
         S_WAIT:  if (wait_exit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_d  = cmd_q;
      pix_d  = pix_q;
      beat_d = beat_q;
      wait_d = '0;
      err_d  = err_q;
      if (state_q == S_LOAD) begin
         pix_d = pix_q + 6'd1;
      end
      if (state_q == S_WAIT) begin
         wait_d = wait_q + WCW'(1);
      end
      // Beat count saturates so a runaway controller can never wrap it back into range.
      if (beat_vld) begin
         if (beat_q != 5'h1f) begin
            beat_d = beat_q + 5'd1;
         end
         if (!beat_wr) begin
            err_d = 1'b1;
         end
      end
      if (wait_exit && (!wait_rel || (beat_q != WIN_FULL))) begin
         err_d = 1'b1;
      end
      if (accept) begin
         cmd_d  = cmd_e'(bus.req_cmd);
         pix_d  = '0;
         beat_d = '0;
         wait_d = '0;
         err_d  = 1'b0;
      end
   end

   always_comb begin
      bus.req_ready = (state_q == S_IDLE);
      bus.cmd_valid = strobe;
      bus.cmd       = cmd_q;
      bus.img_addr  = (state_q == S_LOAD) ? (pix_q + 6'd1) : 6'd0;
      bus.datain    = (state_q == S_LOAD) ? bus.img_data : 8'd0;
      bus.done      = (state_q == S_DONE);
      bus.err       = err_q;
   end

   lcd_win_buf #(
      .DEPTH (WIN_PIXELS),
      .AW    (4),
      .DW    (8)
   ) u_win_buf (
      .clk   (clk),
      .we    (beat_wr),
      .waddr (beat_q[3:0]),
      .wdata (bus.dataout),
      .raddr (bus.win_addr),
      .rdata (bus.win_data)
   );

endmodule

// File: tb/tb_lcd_host.sv
// Directed bench for lcd_host: image load, zoom, busy hold-off, short/long beat runs, timeout, mid-load reset.
module tb_lcd_host;
   logic clk = 1'b0;
   logic reset;
   int   n_pass   = 0;
   int   n_fail   = 0;
   int   n_total  = 0;
   int   n_strobe = 0;
   int   n_done   = 0;

   lcd_host_if bus ();

   lcd_host #(
      .IMG_PIXELS (64),
      .WIN_PIXELS (16),
      .TIMEOUT    (200)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: ROM returns the address seen during the previous cycle (ROM[i] = i).
   task automatic cyc(input logic b, input logic ov, input logic [7:0] d);
      logic [5:0] a;
      a = bus.img_addr;
      @(posedge clk);
      #1;
      bus.img_data     = {2'b00, a};
      bus.busy         = b;
      bus.output_valid = ov;
      bus.dataout      = d;
      #1;
      if (bus.cmd_valid) n_strobe++;
      if (bus.done) n_done++;
   endtask

   task automatic request(input logic [2:0] c);
      bus.req_valid = 1'b1;
      bus.req_cmd   = c;
      chk("req_ready_idle", 32'(bus.req_ready), 1);
      n_strobe = 0;
      n_done   = 0;
   endtask

   task automatic issue(input string tag);
      cyc(1'b0, 1'b0, 8'h00);
      bus.req_valid = 1'b0;
      chk({tag, "_strobe"}, 32'(bus.cmd_valid), 1);
      chk({tag, "_err_clear"}, 32'(bus.err), 0);
   endtask

   task automatic finish_cmd(input string tag, input logic exp_err);
      cyc(1'b0, 1'b0, 8'h00);
      chk({tag, "_datain_idle"}, 32'(bus.datain), 0);
      chk({tag, "_done_early"}, 32'(bus.done), 0);
      cyc(1'b0, 1'b0, 8'h00);
      chk({tag, "_done"}, 32'(bus.done), 1);
      chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      cyc(1'b0, 1'b0, 8'h00);
      chk({tag, "_ready"}, 32'(bus.req_ready), 1);
      chk({tag, "_done_count"}, 32'(n_done), 1);
      chk({tag, "_strobe_count"}, 32'(n_strobe), 1);
   endtask

   task automatic win_chk(input string tag, input logic [3:0] idx, input logic [7:0] exp);
      bus.win_addr = idx;
      #1;
      chk(tag, 32'(bus.win_data), 32'(exp));
   endtask

   initial begin
      int seen;
      reset            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_cmd      = 3'd0;
      bus.img_data     = 8'h00;
      bus.busy         = 1'b0;
      bus.dataout      = 8'h00;
      bus.output_valid = 1'b0;
      bus.win_addr     = 4'd0;

      #2;
      chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
      chk("rst_cmd", 32'(bus.cmd), 0);
      chk("rst_datain", 32'(bus.datain), 0);
      chk("rst_img_addr", 32'(bus.img_addr), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      reset = 1'b1;
      #1;
      chk("rel_req_ready", 32'(bus.req_ready), 1);

      // Image load: datain counts 0..63 from the cycle after the strobe; LCD returns 0,2,4,...
      request(3'd1);
      issue("load");
      chk("load_cmd", 32'(bus.cmd), 1);
      chk("load_addr0", 32'(bus.img_addr), 0);
      for (int n = 0; n < 64; n++) begin
         cyc(1'b1, n < 16, 8'(2 * n));
         chk("load_datain", 32'(bus.datain), 32'(n));
         if (n == 0 || n == 62) chk("load_addr_lead", 32'(bus.img_addr), 32'(n + 1));
      end
      finish_cmd("load", 1'b0);
      win_chk("load_win0", 4'd0, 8'h00);
      win_chk("load_win15", 4'd15, 8'h1e);

      request(3'd2);
      issue("zoom");
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 8'(8'h10 + k));
      finish_cmd("zoom", 1'b0);
      win_chk("zoom_win0", 4'd0, 8'h10);
      win_chk("zoom_win15", 4'd15, 8'h1f);

      // Controller busy for 5 cycles while the command waits; req_valid stays high and must be ignored.
      request(3'd3);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 8'h00);
         chk("hold_no_strobe", 32'(bus.cmd_valid), 0);
      end
      issue("hold");
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 8'(8'h30 + k));
      finish_cmd("hold", 1'b0);

      request(3'd0);
      issue("short");
      for (int k = 0; k < 12; k++) cyc(1'b1, 1'b1, 8'(8'ha0 + k));
      finish_cmd("short", 1'b1);
      win_chk("short_win0", 4'd0, 8'ha0);
      win_chk("short_win12_kept", 4'd12, 8'h3c);

      request(3'd5);
      issue("long");
      for (int k = 0; k < 18; k++) begin
         cyc(1'b1, 1'b1, 8'(8'h40 + k));
         if (k == 16) chk("long_err_at_17th", 32'(bus.err), 0);
         if (k == 17) chk("long_err_after_17th", 32'(bus.err), 1);
      end
      finish_cmd("long", 1'b1);
      win_chk("long_win0", 4'd0, 8'h40);
      win_chk("long_win15", 4'd15, 8'h4f);

      // Controller never releases busy: done lands 200 cycles after WAIT entry.
      request(3'd6);
      issue("tmo");
      seen = -1;
      for (int j = 0; j < 400 && seen < 0; j++) begin
         cyc(1'b1, 1'b0, 8'h00);
         if (bus.done) seen = j;
      end
      chk("tmo_done_cycle", 32'(seen), 200);
      chk("tmo_err", 32'(bus.err), 1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("tmo_ready", 32'(bus.req_ready), 1);
      chk("tmo_done_count", 32'(n_done), 1);

      request(3'd1);
      issue("rst");
      for (int n = 0; n <= 30; n++) cyc(1'b1, n < 16, 8'(2 * n));
      chk("rst_pre_datain", 32'(bus.datain), 30);
      reset = 1'b0;
      #1;
      chk("rst_mid_cmd_valid", 32'(bus.cmd_valid), 0);
      chk("rst_mid_datain", 32'(bus.datain), 0);
      chk("rst_mid_done", 32'(bus.done), 0);
      chk("rst_mid_img_addr", 32'(bus.img_addr), 0);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      reset = 1'b1;
      #1;
      chk("rst_rel_ready", 32'(bus.req_ready), 1);
      chk("rst_rel_err", 32'(bus.err), 0);
      n_strobe = 0;
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 8'h00);
      chk("rst_no_strobe", 32'(n_strobe), 0);

      request(3'd4);
      issue("shr");
      chk("shr_cmd", 32'(bus.cmd), 4);
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 8'(8'h60 + k));
      finish_cmd("shr", 1'b0);
      win_chk("shr_win3", 4'd3, 8'h63);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
